// File: rtl/fir_output_requant.sv
// FIR output requantiser: round, arithmetic shift and saturate the accumulator, then buffer in a small FIFO.
// Define RQ_CONVERGENT_EN to select round-half-to-even instead of round-half-up.
module fir_output_requant #(
  parameter int ACC_WIDTH  = 40,
  parameter int OUT_WIDTH  = 16,
  parameter int SHIFT      = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [ACC_WIDTH-1:0]   in_data,
  input  logic                          in_valid,
  output logic signed [OUT_WIDTH-1:0]   out_data,
  output logic                          out_sat,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fill,
  output logic                          ovf,
  input  logic                          ovf_clr
);

  localparam int SUM_W  = ACC_WIDTH + 1;
  localparam int Q_W    = SUM_W - SHIFT;
  localparam int ENT_W  = OUT_WIDTH + 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FILL_W = PTR_W + 1;

  function automatic logic signed [SUM_W-1:0] round_add(input logic signed [ACC_WIDTH-1:0] x);
    logic [SUM_W-1:0] bias;
`ifdef RQ_CONVERGENT_EN
    // Bit SHIFT of x is the LSB of the truncated result; adding it breaks exact ties toward even.
    bias = (SUM_W'(1) << (SHIFT - 1)) - SUM_W'(1) + SUM_W'(x[SHIFT]);
`else
    bias = SUM_W'(1) << (SHIFT - 1);
`endif
    round_add = $signed({x[ACC_WIDTH-1], x} + bias);
  endfunction

  // Returns {sat, sample}; clipping is detected by the bits above the output sign not matching it.
  function automatic logic [ENT_W-1:0] requant(input logic signed [SUM_W-1:0] s);
    logic signed [Q_W-1:0]     q;
    logic [Q_W-OUT_WIDTH:0]    hi;
    q  = Q_W'(s >>> SHIFT);
    hi = q[Q_W-1:OUT_WIDTH-1];
    if (hi == '0 || hi == '1)
      requant = {1'b0, q[OUT_WIDTH-1:0]};
    else if (q[Q_W-1])
      requant = {1'b1, 1'b1, {(OUT_WIDTH-1){1'b0}}};
    else
      requant = {1'b1, 1'b0, {(OUT_WIDTH-1){1'b1}}};
  endfunction

  logic signed [ACC_WIDTH-1:0] r_acc_p0;
  logic signed [SUM_W-1:0]     r_sum_p1;
  logic [ENT_W-1:0]            r_ent_p2;
  logic                        r_vld_p0, r_vld_p1, r_vld_p2;

  logic [ENT_W-1:0]            r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]            r_wr_ptr, r_rd_ptr;
  logic [FILL_W-1:0]           r_fill;
  logic                        r_ovf;

  logic                        w_full, w_pop, w_wr, w_drop;
  logic [PTR_W-1:0]            w_last_ptr;
  logic [ENT_W-1:0]            w_head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p0 <= 1'b0;
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else begin
      r_vld_p0 <= in_valid;
      r_vld_p1 <= r_vld_p0;
      r_vld_p2 <= r_vld_p1;
    end
  end

  // p0: capture, p1: add rounding bias, p2: shift and saturate
  always_ff @(posedge clk) begin
    r_acc_p0 <= in_data;
    r_sum_p1 <= round_add(r_acc_p0);
    r_ent_p2 <= requant(r_sum_p1);
  end

  assign w_full = (r_fill == FILL_W'(FIFO_DEPTH));
  assign w_pop  = out_valid && out_ready;
  assign w_wr   = r_vld_p2 && (!w_full || w_pop);
  assign w_drop = r_vld_p2 && w_full && !w_pop;

  // FIFO write at the end of the p2 cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
      r_ovf    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= r_ent_p2;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_fill <= r_fill + FILL_W'(w_wr) - FILL_W'(w_pop);
      if (w_drop)
        r_ovf <= 1'b1;
      else if (ovf_clr)
        r_ovf <= 1'b0;
    end
  end

  // When empty, show the most recently popped entry so the output does not jump to stale slots.
  assign w_last_ptr = r_rd_ptr - PTR_W'(1);
  assign w_head     = (r_fill == '0) ? r_mem[w_last_ptr] : r_mem[r_rd_ptr];

  assign out_sat   = w_head[ENT_W-1];
  assign out_data  = $signed(w_head[OUT_WIDTH-1:0]);
  assign out_valid = (r_fill != '0);
  assign fill      = r_fill;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_fir_output_requant.sv
// Scoreboard bench for fir_output_requant: directed vectors with hand-computed results.
module tb_fir_output_requant;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [39:0] in_data = '0;
  logic               in_valid = 1'b0;
  logic signed [15:0] out_data;
  logic               out_sat;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [2:0]         fill;
  logic               ovf;
  logic               ovf_clr = 1'b0;

  int total = 0;
  int bad   = 0;
  logic [16:0] exp_q [$];
  logic [16:0] e;

  logic signed [39:0] vin  [13];
  logic signed [15:0] vexp [13];
  logic               vsat [13];

  fir_output_requant #(
    .ACC_WIDTH(40), .OUT_WIDTH(16), .SHIFT(15), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_sat(out_sat), .out_valid(out_valid), .out_ready(out_ready),
    .fill(fill), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [39:0] got, input logic [39:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Monitor: every accepted output is compared against the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out got=%0d sat=%0b", out_data, out_sat);
      end else begin
        e = exp_q.pop_front();
        if ({out_sat, out_data} !== e) begin
          bad++;
          $display("FAIL sample got=%0d sat=%0b exp=%0d sat=%0b",
                   out_data, out_sat, $signed(e[15:0]), e[16]);
        end
      end
    end
  end

  task automatic send(input logic signed [39:0] v, input logic signed [15:0] d,
                      input logic s, input logic keep);
    in_data  = v;
    in_valid = 1'b1;
    if (keep) exp_q.push_back({s, d});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic lat_test(input logic signed [39:0] v, input logic signed [15:0] d,
                          input logic s, input string nm);
    send(v, d, s, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk({nm, "_early"}, out_valid, 0);
    end
    @(negedge clk);
    chk({nm, "_lat3"}, out_valid, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_fill(input int n, input string nm);
    for (int i = 0; i < 40 && fill != n; i++) begin
      @(posedge clk); #1;
    end
    chk(nm, fill, n);
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0 && fill == 0) break;
      @(posedge clk); #1;
    end
    chk(nm, (exp_q.size() == 0 && fill == 0), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vin[0]  =  40'sd49152;        vexp[0]  =  16'sd2;     vsat[0]  = 1'b0;
`ifdef RQ_CONVERGENT_EN
    vin[1]  = -40'sd49152;        vexp[1]  = -16'sd2;     vsat[1]  = 1'b0;
    vin[2]  =  40'sd16384;        vexp[2]  =  16'sd0;     vsat[2]  = 1'b0;
`else
    vin[1]  = -40'sd49152;        vexp[1]  = -16'sd1;     vsat[1]  = 1'b0;
    vin[2]  =  40'sd16384;        vexp[2]  =  16'sd1;     vsat[2]  = 1'b0;
`endif
    vin[3]  = -40'sd16384;        vexp[3]  =  16'sd0;     vsat[3]  = 1'b0;
    vin[4]  =  40'sd2147483648;   vexp[4]  =  16'sd32767; vsat[4]  = 1'b1;
    vin[5]  = -40'sd2147483648;   vexp[5]  = -16'sd32768; vsat[5]  = 1'b1;
    vin[6]  =  40'sh7F_FFFF_FFFF; vexp[6]  =  16'sd32767; vsat[6]  = 1'b1;
    vin[7]  =  40'sd3276800;      vexp[7]  =  16'sd100;   vsat[7]  = 1'b0;
    vin[8]  = -40'sd163840;       vexp[8]  = -16'sd5;     vsat[8]  = 1'b0;
    vin[9]  =  40'sd1073709056;   vexp[9]  =  16'sd32767; vsat[9]  = 1'b0;
    vin[10] = -40'sd1073741824;   vexp[10] = -16'sd32768; vsat[10] = 1'b0;
    vin[11] =  40'sd1073725440;   vexp[11] =  16'sd32767; vsat[11] = 1'b1;
    vin[12] = -40'sd1073758209;   vexp[12] = -16'sd32768; vsat[12] = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fill", fill, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    lat_test(vin[0], vexp[0], vsat[0], "lat_a");
    for (int i = 1; i < 13; i++) send(vin[i], vexp[i], vsat[i], 1'b1);
    drain("drain_round");

    // Back-pressure: fifth sample must be dropped
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) send(40'(k * 32768), 16'(k), 1'b0, k <= 4);
    repeat (4) begin @(posedge clk); #1; end
    chk("ovf_fill", fill, 4);
    chk("ovf_set", ovf, 1);
    chk("ovf_out_valid", out_valid, 1);
    chk("ovf_head", out_data, 1);
    out_ready = 1'b1;
    drain("drain_ovf");
    chk("ovf_sticky", ovf, 1);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    chk("ovf_clr", ovf, 0);

    // Full FIFO with pop and write on the same edge
    out_ready = 1'b0;
    for (int k = 10; k <= 13; k++) send(40'(k * 32768), 16'(k), 1'b0, 1'b1);
    wait_fill(4, "full_fill");
    send(40'(14 * 32768), 16'sd14, 1'b0, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("simul_fill", fill, 4);
    chk("simul_ovf", ovf, 0);

    // Drop and clear on the same edge: the set must win
    send(40'(15 * 32768), 16'sd15, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    chk("set_wins_ovf", ovf, 1);
    chk("set_wins_fill", fill, 4);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    chk("clr_after", ovf, 0);
    out_ready = 1'b1;
    drain("drain_full");

    // Asynchronous reset with three entries buffered
    out_ready = 1'b0;
    for (int k = 20; k <= 22; k++) send(40'(k * 32768), 16'(k), 1'b0, 1'b1);
    wait_fill(3, "pre_rst_fill");
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_fill", fill, 0);
    chk("arst_out_data", out_data, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    lat_test(40'sd229376, 16'sd7, 1'b0, "lat_b");
    drain("drain_post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
